// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared types and constants for the staged reset sequencer.
//   state_t    : sequencer FSM states
//   DEF_*      : default parameter values
//   cnt_width(): bit width needed for the shared stage counter
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT   = 2'd0,
      RELEASE  = 2'd1,
      WAIT_RDY = 2'd2,
      RUN      = 2'd3
   } state_t;

   localparam int DEF_NUM_DOMAINS    = 3;
   localparam int DEF_ASSERT_CYCLES  = 8;
   localparam int DEF_HOLD_CYCLES    = 4;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   // The counter must reach (largest period - 1) and is never allowed to wrap.
   function automatic int cnt_width(input int assert_c, input int hold_c, input int timeout_c);
      int m;
      m = assert_c;
      if (hold_c > m) m = hold_c;
      if (timeout_c > m) m = timeout_c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seq_counter.sv
// seq_counter
// Loadable up-counter with clear and a terminal-match flag.
//   clk, reset   : clock, synchronous active-high reset (clears count)
//   clr_i        : clear to zero (highest priority after reset)
//   load_i       : load load_val_i
//   inc_i        : increment by one
//   load_val_i   : value loaded when load_i is high
//   term_i       : terminal value to compare against
//   term_o       : high while the current count equals term_i
module seq_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         inc_i,
   input  logic [W-1:0] load_val_i,
   input  logic [W-1:0] term_i,
   output logic         term_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Holds every downstream domain in reset for ASSERT_CYCLES, then releases the
// domains one at a time in index order, waiting for each domain's ready
// handshake before moving on. A ready that never arrives flags a sticky error
// and restarts the whole sequence.
//   clk, reset    : clock, synchronous active-high system reset
//   soft_rst_i    : soft restart request (re-asserts all domain resets)
//   ready_i[k]    : domain k finished initialising after its reset released
//   rst_o[k]      : per-domain active-high reset, registered
//   busy_o        : high whenever the sequencer is not in RUN
//   done_o        : one-cycle pulse on entry to RUN
//   err_o         : sticky ready-timeout flag, cleared only by reset
//   dbg_state_o   : current FSM state
//
// Handshake: ready_i[idx] is only looked at while in WAIT_RDY for the domain
// currently being released; it is a level, sampled on every WAIT_RDY edge,
// and other ready bits are ignored.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
   parameter int ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   soft_rst_i,
   input  logic [NUM_DOMAINS-1:0] ready_i,
   output logic [NUM_DOMAINS-1:0] rst_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output state_t                 dbg_state_o
);

   localparam int CW = cnt_width(ASSERT_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CW-1:0] ASSERT_TERM  = CW'(ASSERT_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_TERM    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_TERM = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DOMAINS - 1);
   localparam logic [IW-1:0] IDX_ONE      = IW'(1);

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   cnt_clr;
   logic                   cnt_inc;
   logic                   cnt_term;
   logic [CW-1:0]          cnt_term_val;

   // One counter serves all timed states; its terminal value follows the state.
   always_comb begin
      cnt_term_val = ASSERT_TERM;
      case (state_q)
         ASSERT:   cnt_term_val = ASSERT_TERM;
         RELEASE:  cnt_term_val = HOLD_TERM;
         WAIT_RDY: cnt_term_val = TIMEOUT_TERM;
         default:  cnt_term_val = ASSERT_TERM;
      endcase
   end

   seq_counter #(
      .W (CW)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (cnt_clr),
      .load_i     (1'b0),
      .inc_i      (cnt_inc),
      .load_val_i ({CW{1'b0}}),
      .term_i     (cnt_term_val),
      .term_o     (cnt_term)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;

      if (soft_rst_i) begin
         // Held high, this keeps re-entering ASSERT with a cleared count.
         state_d = ASSERT;
         idx_d   = '0;
         rst_d   = '1;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            ASSERT: begin
               rst_d = '1;
               if (cnt_term) begin
                  state_d = RELEASE;
                  idx_d   = '0;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            RELEASE: begin
               if (cnt_term) begin
                  rst_d[idx_q] = 1'b0;
                  state_d      = WAIT_RDY;
                  cnt_clr      = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            WAIT_RDY: begin
               if (ready_i[idx_q]) begin
                  cnt_clr = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     idx_d   = idx_q + IDX_ONE;
                     state_d = RELEASE;
                  end
               end else if (cnt_term) begin
                  // Domain never came up: flag it and retry the full sequence.
                  err_d   = 1'b1;
                  state_d = ASSERT;
                  idx_d   = '0;
                  rst_d   = '1;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            RUN: begin
               rst_d = '0;
            end
            default: begin
               state_d = ASSERT;
               idx_d   = '0;
               rst_d   = '1;
               cnt_clr = 1'b1;
            end
         endcase
      end

      busy_d = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ASSERT;
         idx_q   <= '0;
         rst_q   <= '1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign rst_o       = rst_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters. The driver pushes
// the expected output record {edge, rst_o, busy_o, done_o, err_o} for every
// output change it anticipates; the monitor pops and compares a record each
// time the sampled outputs change.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       soft_rst_i;
   logic [2:0] ready_i;
   logic [2:0] rst_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   state_t     dbg_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [37:0] exp_q[$];
   logic [5:0]  prev_out = 6'bxxxxxx;

   reset_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .soft_rst_i  (soft_rst_i),
      .ready_i     (ready_i),
      .rst_o       (rst_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / edge counter ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic push(input int e, input logic [2:0] r, input logic b, input logic d, input logic er);
      exp_q.push_back({32'(e), r, b, d, er});
   endtask

   // Advance until edge k has happened; returns #1 after that edge.
   task automatic goto_edge(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Standard release pattern after a restart ends at edge 'base'.
   task automatic push_normal(input int base, input logic er);
      push(base + 12, 3'b110, 1'b1, 1'b0, er);
      push(base + 17, 3'b100, 1'b1, 1'b0, er);
      push(base + 22, 3'b000, 1'b1, 1'b0, er);
      push(base + 23, 3'b000, 1'b0, 1'b1, er);
      push(base + 24, 3'b000, 1'b0, 1'b0, er);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [37:0] obs;
      logic [37:0] exp;
      obs = {32'(cyc), rst_o, busy_o, done_o, err_o};
      if (obs[5:0] !== prev_out) begin
         prev_out = obs[5:0];
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_change: unexpected change at edge %0d got rst=%b busy=%b done=%b err=%b, required no change",
                     cyc, rst_o, busy_o, done_o, err_o);
         end else begin
            exp = exp_q.pop_front();
            if (exp !== obs) begin
               failures++;
               $display("FAIL out_change: got edge=%0d rst=%b busy=%b done=%b err=%b, required edge=%0d rst=%b busy=%b done=%b err=%b",
                        obs[37:6], obs[5:3], obs[2], obs[1], obs[0],
                        exp[37:6], exp[5:3], exp[2], exp[1], exp[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int p;

      // A: power-on reset for 3 edges, all domains ready.
      reset      = 1'b1;
      soft_rst_i = 1'b0;
      ready_i    = 3'b111;
      push(1, 3'b111, 1'b1, 1'b0, 1'b0);
      goto_edge(3);
      reset = 1'b0;
      base  = cyc;
      push_normal(base, 1'b0);
      goto_edge(base + 30);

      // B: domain 1 stalls until ready_i[1] is raised after edge 30.
      reset   = 1'b1;
      ready_i = 3'b101;
      p = cyc + 1;
      push(p, 3'b111, 1'b1, 1'b0, 1'b0);
      goto_edge(p);
      reset = 1'b0;
      base  = p;
      push(base + 12, 3'b110, 1'b1, 1'b0, 1'b0);
      push(base + 17, 3'b100, 1'b1, 1'b0, 1'b0);
      goto_edge(base + 30);
      ready_i = 3'b111;
      push(base + 35, 3'b000, 1'b1, 1'b0, 1'b0);
      push(base + 36, 3'b000, 1'b0, 1'b1, 1'b0);
      push(base + 37, 3'b000, 1'b0, 1'b0, 1'b0);
      goto_edge(base + 40);

      // C: domain 0 never ready -> timeout, sticky error, retry, then recover.
      reset   = 1'b1;
      ready_i = 3'b110;
      p = cyc + 1;
      push(p, 3'b111, 1'b1, 1'b0, 1'b0);
      goto_edge(p);
      reset = 1'b0;
      base  = p;
      push(base + 12, 3'b110, 1'b1, 1'b0, 1'b0);
      push(base + 76, 3'b111, 1'b1, 1'b0, 1'b1);
      push(base + 88, 3'b110, 1'b1, 1'b0, 1'b1);
      goto_edge(base + 100);
      ready_i = 3'b111;
      push(base + 105, 3'b100, 1'b1, 1'b0, 1'b1);
      push(base + 110, 3'b000, 1'b1, 1'b0, 1'b1);
      push(base + 111, 3'b000, 1'b0, 1'b1, 1'b1);
      push(base + 112, 3'b000, 1'b0, 1'b0, 1'b1);
      goto_edge(base + 120);

      // D: one-cycle soft reset in RUN; error flag must survive.
      soft_rst_i = 1'b1;
      p = cyc + 1;
      push(p, 3'b111, 1'b1, 1'b0, 1'b1);
      goto_edge(p);
      soft_rst_i = 1'b0;
      base = p;
      push_normal(base, 1'b1);
      goto_edge(base + 30);

      // E: soft reset in the middle of stage 1's hold period.
      soft_rst_i = 1'b1;
      p = cyc + 1;
      push(p, 3'b111, 1'b1, 1'b0, 1'b1);
      goto_edge(p);
      soft_rst_i = 1'b0;
      base = p;
      push(base + 12, 3'b110, 1'b1, 1'b0, 1'b1);
      goto_edge(base + 14);
      soft_rst_i = 1'b1;
      push(base + 15, 3'b111, 1'b1, 1'b0, 1'b1);
      goto_edge(base + 15);
      soft_rst_i = 1'b0;
      base = cyc;
      push_normal(base, 1'b1);
      goto_edge(base + 30);

      // F: reset and soft reset together while waiting on domain 1.
      ready_i    = 3'b101;
      soft_rst_i = 1'b1;
      p = cyc + 1;
      push(p, 3'b111, 1'b1, 1'b0, 1'b1);
      goto_edge(p);
      soft_rst_i = 1'b0;
      base = p;
      push(base + 12, 3'b110, 1'b1, 1'b0, 1'b1);
      push(base + 17, 3'b100, 1'b1, 1'b0, 1'b1);
      goto_edge(base + 19);
      reset      = 1'b1;
      soft_rst_i = 1'b1;
      push(base + 20, 3'b111, 1'b1, 1'b0, 1'b0);
      goto_edge(base + 21);
      reset      = 1'b0;
      soft_rst_i = 1'b0;
      ready_i    = 3'b111;
      base = cyc;
      push_normal(base, 1'b0);
      goto_edge(base + 30);

      // Final report.
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL exp_q_drain: got %0d pending records, required 0", exp_q.size());
      end
      checks++;
      if (dbg_state != RUN) begin
         failures++;
         $display("FAIL final_state: got %0d, required %0d", dbg_state, RUN);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
